fetch_stage: RTL and testbench

- Owns the program counter (PC) and the F/D pipeline register. It is the stage directly upstream of the decode stage.
- Each cycle it presents F_pc to the external instruction memory and detects fetch-address exceptions (AdEL).
- It steers the next PC from the decode-stage next-PC, the exception handler vector, or EPC on eret.
- It supplies D_pc, D_inStr, D_ExcCode and D_isBD to decode.
- Stall, exception flush and eret flush are resolved here.

---
 rtl/fetch_stage_pkg.sv | 25 ++
 rtl/fetch_stage_fd_reg.sv | 26 ++
 rtl/fetch_stage.sv | 62 ++++++
 tb/tb_fetch_stage.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared exception codes, address map constants and F/D record type
package fetch_stage_pkg;
    localparam logic [31:0] PC_RESET   = 32'h0000_3000;
    localparam logic [31:0] HANDLER_PC = 32'h0000_4180;
    localparam logic [31:0] IM_LO      = 32'h0000_3000;
    localparam logic [31:0] IM_HI      = 32'h0000_6FFC;
    localparam logic [4:0]  EXC_NONE   = 5'd0;
    localparam logic [4:0]  EXC_ADEL   = 5'd4;
    localparam logic [4:0]  EXC_SYS    = 5'd8;
    localparam logic [4:0]  EXC_RI     = 5'd10;
    localparam logic        TRUE       = 1'b1;
    localparam logic        FALSE      = 1'b0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  exc;
        logic        isbd;
    } fd_t;

    // Misaligned or outside the instruction memory window
    function automatic logic adel(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a < IM_LO) || (a > IM_HI);
    endfunction
endpackage

// File: rtl/fetch_stage_fd_reg.sv
// fd_reg: 70-bit F/D pipeline register with flush-to-bubble and hold
// Ports: clk, reset (async active-low), i_en (load), i_flush (bubble, wins over
// i_en), i_flush_pc (pc carried by the bubble), i_d (F-side record), o_q (D-side record)
module fd_reg
    import fetch_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_en,
    input  logic        i_flush,
    input  logic [31:0] i_flush_pc,
    input  fd_t         i_d,
    output fd_t         o_q
);
    fd_t r_q;

    always_ff @(posedge clk or negedge reset)
        if (!reset)
            r_q <= '{pc: PC_RESET, instr: 32'h0, exc: EXC_NONE, isbd: FALSE};
        else if (i_flush)
            r_q <= '{pc: i_flush_pc, instr: 32'h0, exc: EXC_NONE, isbd: FALSE};
        else if (i_en)
            r_q <= i_d;

    assign o_q = r_q;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC register, AdEL detection, next-PC steering and F/D register
// Ports: clk, reset (async active-low), F_inStr_mem (IM data), D_nextpc, F_isBD,
// D_eret, EPC, stall, req (CP0 exception taken) in; F_pc (to IM), D_pc, D_inStr,
// D_ExcCode, D_isBD (to decode) out
module fetch_stage
    import fetch_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] F_inStr_mem,
    input  logic [31:0] D_nextpc,
    input  logic        F_isBD,
    input  logic        D_eret,
    input  logic [31:0] EPC,
    input  logic        stall,
    input  logic        req,
    output logic [31:0] F_pc,
    output logic [31:0] D_pc,
    output logic [31:0] D_inStr,
    output logic [4:0]  D_ExcCode,
    output logic        D_isBD
);
    logic [31:0] r_pc;
    logic [31:0] w_next_pc;
    logic        w_adel;
    logic        w_flush;
    logic        w_en;
    fd_t         w_f;
    fd_t         w_d;

    assign F_pc   = r_pc;
    assign w_adel = adel(r_pc);
    // Forced zero keeps a bad fetch's (possibly X) memory data out of decode
    assign w_f    = '{pc: r_pc, instr: w_adel ? 32'h0 : F_inStr_mem,
                      exc: w_adel ? EXC_ADEL : EXC_NONE, isbd: F_isBD};

    // req beats stall; a stalled eret waits and is re-evaluated next cycle
    assign w_flush   = req | (D_eret & ~stall);
    assign w_en      = ~stall;
    assign w_next_pc = req ? HANDLER_PC : stall ? r_pc : D_eret ? EPC : D_nextpc;

    always_ff @(posedge clk or negedge reset)
        if (!reset)
            r_pc <= PC_RESET;
        else
            r_pc <= w_next_pc;

    fd_reg u_fd_reg (
        .clk        (clk),
        .reset      (reset),
        .i_en       (w_en),
        .i_flush    (w_flush),
        .i_flush_pc (req ? HANDLER_PC : EPC),
        .i_d        (w_f),
        .o_q        (w_d)
    );

    assign D_pc      = w_d.pc;
    assign D_inStr   = w_d.instr;
    assign D_ExcCode = w_d.exc;
    assign D_isBD    = w_d.isbd;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed self-checking bench for fetch_stage
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] F_inStr_mem = 32'h0;
    logic [31:0] D_nextpc = 32'h0;
    logic        F_isBD = 1'b0;
    logic        D_eret = 1'b0;
    logic [31:0] EPC = 32'h0;
    logic        stall = 1'b0;
    logic        req = 1'b0;
    logic [31:0] F_pc, D_pc, D_inStr;
    logic [4:0]  D_ExcCode;
    logic        D_isBD;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk(clk), .reset(reset), .F_inStr_mem(F_inStr_mem), .D_nextpc(D_nextpc),
        .F_isBD(F_isBD), .D_eret(D_eret), .EPC(EPC), .stall(stall), .req(req),
        .F_pc(F_pc), .D_pc(D_pc), .D_inStr(D_inStr), .D_ExcCode(D_ExcCode), .D_isBD(D_isBD)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_d(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                         input logic [4:0] exc, input logic bd);
        chk({tag, ".D_pc"}, D_pc, pc);
        chk({tag, ".D_inStr"}, D_inStr, ins);
        chk({tag, ".D_ExcCode"}, {27'h0, D_ExcCode}, {27'h0, exc});
        chk({tag, ".D_isBD"}, {31'h0, D_isBD}, {31'h0, bd});
    endtask

    // One rising edge, then sample on the following falling edge
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        D_nextpc = 32'h3004;
        F_inStr_mem = 32'h1111_1111;
        repeat (3) begin
            step();
            chk("rst.F_pc", F_pc, 32'h3000);
        end
        chk_d("rst", 32'h3000, 32'h0, 5'd0, 1'b0);
        reset = 1'b1;
        #1 chk("rel.F_pc", F_pc, 32'h3000);
        step();
        chk("first.F_pc", F_pc, 32'h3004);
        chk_d("first", 32'h3000, 32'h1111_1111, 5'd0, 1'b0);

        stall = 1'b1;
        D_nextpc = 32'h3010;
        F_inStr_mem = 32'h2222_2222;
        repeat (2) begin
            step();
            chk("stall.F_pc", F_pc, 32'h3004);
            chk_d("stall", 32'h3000, 32'h1111_1111, 5'd0, 1'b0);
        end
        stall = 1'b0;
        step();
        chk("resume.F_pc", F_pc, 32'h3010);
        chk_d("resume", 32'h3004, 32'h2222_2222, 5'd0, 1'b0);

        D_nextpc = 32'h3002;
        F_inStr_mem = 32'h3333_3333;
        step();
        chk("mis.F_pc", F_pc, 32'h3002);
        chk_d("mis0", 32'h3010, 32'h3333_3333, 5'd0, 1'b0);
        D_nextpc = 32'h3008;
        F_inStr_mem = 32'h4444_4444;
        step();
        chk("mis1.F_pc", F_pc, 32'h3008);
        chk_d("mis1", 32'h3002, 32'h0, 5'd4, 1'b0);

        req = 1'b1;
        stall = 1'b1;
        D_nextpc = 32'h300C;
        F_inStr_mem = 32'h5555_5555;
        F_isBD = 1'b1;
        step();
        chk("req.F_pc", F_pc, 32'h4180);
        chk_d("req", 32'h4180, 32'h0, 5'd0, 1'b0);

        req = 1'b0;
        stall = 1'b0;
        F_isBD = 1'b0;
        D_eret = 1'b1;
        EPC = 32'h3040;
        D_nextpc = 32'h4184;
        F_inStr_mem = 32'h6666_6666;
        step();
        chk("eret.F_pc", F_pc, 32'h3040);
        chk_d("eret", 32'h3040, 32'h0, 5'd0, 1'b0);

        stall = 1'b1;
        EPC = 32'h3080;
        step();
        chk("eretstall.F_pc", F_pc, 32'h3040);
        chk_d("eretstall", 32'h3040, 32'h0, 5'd0, 1'b0);

        D_eret = 1'b0;
        stall = 1'b0;
        D_nextpc = 32'h8000;
        F_inStr_mem = 32'h7777_7777;
        step();
        chk("oor.F_pc", F_pc, 32'h8000);
        chk_d("oor0", 32'h3040, 32'h7777_7777, 5'd0, 1'b0);
        F_isBD = 1'b1;
        D_nextpc = 32'h6FFC;
        F_inStr_mem = 32'h8888_8888;
        step();
        chk_d("bdadel", 32'h8000, 32'h0, 5'd4, 1'b1);

        F_isBD = 1'b0;
        D_nextpc = 32'h7000;
        F_inStr_mem = 32'h9999_9999;
        step();
        chk_d("imhi", 32'h6FFC, 32'h9999_9999, 5'd0, 1'b0);
        D_nextpc = 32'h2FFC;
        F_inStr_mem = 32'hAAAA_AAAA;
        step();
        chk_d("abovehi", 32'h7000, 32'h0, 5'd4, 1'b0);
        D_nextpc = 32'h3000;
        F_inStr_mem = 32'hBBBB_BBBB;
        step();
        chk_d("belowlo", 32'h2FFC, 32'h0, 5'd4, 1'b0);
        D_nextpc = 32'h3004;
        F_inStr_mem = 32'hCCCC_CCCC;
        step();
        chk_d("imlo", 32'h3000, 32'hCCCC_CCCC, 5'd0, 1'b0);

        stall = 1'b1;
        D_eret = 1'b1;
        #2 reset = 1'b0;
        #1 chk("arst.F_pc", F_pc, 32'h3000);
        chk_d("arst", 32'h3000, 32'h0, 5'd0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
